nibble_serial_adder: RTL
========================

// Module: nibble_serial_adder
// PURPOSE
//  Sequencer that wraps the team's 4-bit carry-lookahead adder cell (carryadder) to add or subtract WIDTH-bit operands.
//  Processes one nibble per clock, least significant first, and registers the carry between nibbles.
//  Accepts operands on a valid/ready input port and returns sum/cout/overflow on a valid/ready output port.
// PARAMETERS
//  WIDTH   16   operand/result width; multiple of 4, >= 4
//  NIB     WIDTH/4 (localparam)   nibbles per operation; counter width = clog2(NIB)+1
// PORTS
//  clk        in   1      single clock, all state updates on rising edge
//  rst_n      in   1      synchronous, active-low reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      block can accept operands (IDLE only)
//  op_a       in   WIDTH  operand A
//  op_b       in   WIDTH  operand B
//  cin        in   1      carry-in for add; ignored when op_sub=1
//  op_sub     in   1      1: compute A-B as A + ~B + 1
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result, modulo 2^WIDTH
//  cout       out  1      carry out of MSB (for sub: 1 = no borrow)
//  ovf        out  1      two's-complement signed overflow
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset: rst_n=0 at a clk edge -> state IDLE; out_valid, sum, cout, ovf, busy = 0; in_ready = 1.
//   Applies in any state; an in-flight operation is discarded and no result is produced.
//  FSM IDLE -> RUN -> DONE -> IDLE. in_ready = (state==IDLE); out_valid = (state==DONE).
//  IDLE, in_valid=1 at edge: latch op_a into a_sh and (op_b ^ {WIDTH{op_sub}}) into b_sh.
//   Load carry = op_sub ? 1 : cin. Store the MSBs of A and effective B. Clear nib_cnt. Go to RUN.
//  RUN, each cycle: CLA inputs = a_sh[3:0], b_sh[3:0], c0 = carry.
//   At the edge: shift a_sh and b_sh right by 4; shift CLA s[3:0] into res[WIDTH-1:WIDTH-4] (res shifts right by 4).
//   Also at the edge: carry <= c4; nib_cnt++.
//   When nib_cnt == NIB-1 at the edge -> DONE. sum <= final res; cout <= c4.
//   ovf <= (a_msb == beff_msb) && (res MSB != a_msb).
//  Latency: accept edge k -> out_valid high from edge k+NIB. Minimum issue interval NIB+2 cycles.
//  DONE: hold out_valid, sum, cout and ovf stable until out_ready=1 at an edge -> IDLE. Outputs remain at their last values.
//  in_valid outside IDLE is ignored (not accepted, not queued). op_* are sampled only on the accept edge.
//  WIDTH=4 (NIB=1): RUN lasts exactly one cycle.
//  Carry chaining uses only carryadder c4. No second adder path and no combinational path from in_* to out_*.
// STRUCTURE
//  Shared package nsa_pkg: state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and NIB_W=4.
//  One sub-module: carryadder (4-bit CLA cell), instantiated once with the nibble datapath.
//  All other logic (FSM, shift regs, counter, carry reg) is local to this module.
// TESTING  (WIDTH=16 unless noted)
//  A=0x1234, B=0x4321, cin=0, add -> sum=0x5555, cout=0, ovf=0. out_valid exactly 4 cycles after the accept edge.
//  A=0xFFFF, B=0x0001, add -> sum=0x0000, cout=1, ovf=0 (carry crosses all 4 nibbles). A=0x7FFF, B=0x0001 -> sum=0x8000, ovf=1, cout=0.
//  Sub A=0x0005, B=0x0007 -> sum=0xFFFE, cout=0, ovf=0. Sub A=0x8000, B=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
//  Hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands -> sum/cout/ovf stable and in_ready=0.
//   The new operands are not accepted. After out_ready=1, state returns to IDLE and in_ready=1.
//  rst_n=0 for one edge after 2 RUN cycles -> all outputs 0, in_ready=1 next cycle, no out_valid pulse.
//   The next op (0x00FF+0x0F01) gives 0x1000.
//  Random sweep, WIDTH=16 and WIDTH=4, 10k ops with random out_ready stalls -> matches reference model {cout,sum}=A+B+cin or A-B.

Source files
------------

// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder and its CLA cell.
package nsa_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : nsa_pkg

// File: rtl/carryadder.sv
// 4-bit carry-lookahead adder cell: purely combinational nibble add.
module carryadder
  import nsa_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  input  logic             c0_i,
  output logic [NIB_W-1:0] s_o,
  output logic             c4_o
);

  logic [NIB_W-1:0] g;
  logic [NIB_W-1:0] p;
  logic [NIB_W:0]   c;

  // Generate/propagate terms and flattened lookahead carries.
  always_comb begin
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    c[0] = c0_i;
    c[1] = g[0] | (p[0] & c0_i);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0_i);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c0_i);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0_i);
    s_o  = p ^ c[NIB_W-1:0];
    c4_o = c[4];
  end

endmodule : carryadder

// File: rtl/nibble_serial_adder.sv
// Nibble-serial add/subtract sequencer around a single 4-bit CLA cell.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NIB   = WIDTH / NIB_W;
  localparam int unsigned CNT_W = $clog2(NIB) + 1;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic             a_msb_q;
  logic             beff_msb_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             out_valid_q;
  logic             in_ready_q;
  logic             busy_q;

  logic [NIB_W-1:0] cla_s;
  logic             cla_c4;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] res_d;
  logic             last_nib;

  carryadder u_cla (
    .a_i  (a_sh_q[NIB_W-1:0]),
    .b_i  (b_sh_q[NIB_W-1:0]),
    .c0_i (carry_q),
    .s_o  (cla_s),
    .c4_o (cla_c4)
  );

  // Effective B, next result window (new nibble enters at the top) and last-nibble flag.
  always_comb begin
    b_eff    = op_b ^ {WIDTH{op_sub}};
    res_d    = WIDTH'({cla_s, res_q} >> NIB_W);
    last_nib = (cnt_q == CNT_W'(NIB - 1));
  end

  // Sequencer: accept in IDLE, one nibble per cycle in RUN, hold result in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      a_msb_q     <= 1'b0;
      beff_msb_q  <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_q     <= op_a;
            b_sh_q     <= b_eff;
            carry_q    <= op_sub | cin;
            a_msb_q    <= op_a[WIDTH-1];
            beff_msb_q <= b_eff[WIDTH-1];
            cnt_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          a_sh_q  <= a_sh_q >> NIB_W;
          b_sh_q  <= b_sh_q >> NIB_W;
          res_q   <= res_d;
          carry_q <= cla_c4;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_nib) begin
            state_q     <= DONE;
            sum_q       <= res_d;
            cout_q      <= cla_c4;
            ovf_q       <= (a_msb_q == beff_msb_q) && (res_d[WIDTH-1] != a_msb_q);
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;

endmodule : nibble_serial_adder
